// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - funct3 encodings and LSU state type shared by the load/store unit
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for stores and extraction/extension for loads
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_val,
    output logic        misaligned
);

    logic [31:0] shifted;

    // Store and load encodings share funct3 values, so one decode serves both;
    // the reserved encodings 011/110/111 fall through to word behaviour.
    always_comb begin
        shifted    = rword >> {off, 3'b000};
        be         = 4'b1111;
        lane_wdata = wdata;
        load_val   = shifted;
        misaligned = 1'b0;
        case (funct3)
            F3_LB, F3_LBU: begin
                be         = 4'b0001 << off;
                lane_wdata = {4{wdata[7:0]}};
                load_val   = funct3[2] ? {24'b0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_LH, F3_LHU: begin
                be         = 4'b0011 << off;
                lane_wdata = {2{wdata[15:0]}};
                load_val   = funct3[2] ? {16'b0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
                misaligned = off[0];
            end
            default: begin
                misaligned = |off;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory access stage with req/ready handshake, stall and timeout
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);

    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_t    state_q, state_d;
    logic [29:0]   addr_q;
    logic [1:0]    off_q;
    logic [2:0]    funct3_q;
    logic          we_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic [CW-1:0] cnt_q;
    logic          err_q;
    logic          start;

    logic [2:0]    al_funct3;
    logic [1:0]    al_off;
    logic [3:0]    al_be;
    logic [31:0]   al_wdata;
    logic [31:0]   al_load;
    logic          al_mis;

    // One aligner serves both phases: live command fields while IDLE,
    // latched fields while the response word is being extracted.
    assign al_funct3 = (state_q == IDLE) ? funct3    : funct3_q;
    assign al_off    = (state_q == IDLE) ? addr[1:0] : off_q;

    lsu_align u_align (
        .funct3     (al_funct3),
        .off        (al_off),
        .wdata      (wdata),
        .rword      (dmem_rdata),
        .be         (al_be),
        .lane_wdata (al_wdata),
        .load_val   (al_load),
        .misaligned (al_mis)
    );

    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        misaligned = 1'b0;
        dmem_req   = 1'b0;
        bus_err    = 1'b0;
        start      = 1'b0;
        // Combinational outputs are forced low while reset is held.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        if (al_mis) begin
                            misaligned = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            start   = 1'b1;
                            state_d = ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    dmem_req = 1'b1;
                    stall    = 1'b1;
                    if (dmem_ready || (cnt_q == CNT_LAST)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    bus_err = err_q;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            off_q    <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                addr_q   <= addr[31:2];
                off_q    <= addr[1:0];
                funct3_q <= funct3;
                we_q     <= mem_write;
                be_q     <= mem_write ? al_be : 4'b1111;
                wdata_q  <= al_wdata;
                cnt_q    <= '0;
                err_q    <= 1'b0;
            end else if (state_q == ACCESS) begin
                if (dmem_ready) begin
                    rdata_q <= we_q ? 32'b0 : al_load;
                end else if (cnt_q == CNT_LAST) begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign rdata      = misaligned ? 32'b0 : rdata_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = {addr_q, 2'b00};
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;

endmodule
